regfile_wb_sched: RTL and testbench
===================================

Name: regfile_wb_sched

Overview:
- Write-port scheduler for the 32x32 register file, which has one write port sampled on the falling clock edge.
- Shares that port between the in-order pipeline writeback and a long-latency multiply/divide unit (MDU).
- Holds a small result FIFO for the MDU and a per-register pending-write scoreboard.
- Generates decode-stage stall and anti-starvation pipeline hold signals.

Parameters:
DW, 32, data width of register and write data
AW, 5, register index width (2**AW registers)
FIFO_DEPTH, 2, MDU result buffer entries (power of 2, >=2)
MAX_WAIT, 4, cycles a buffered MDU result may lose arbitration before a pipeline hold is forced

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
PipeWe  in  1  pipeline writeback request this cycle
PipeRegNum  in  AW  pipeline destination register
PipeData  in  DW  pipeline writeback data
MdValid  in  1  MDU result valid
MdReady  out  1  MDU result accepted (= FIFO not full)
MdRegNum  in  AW  MDU destination register
MdData  in  DW  MDU result data
IssueValid  in  1  decode issues an MDU op this cycle
IssueRegNum  in  AW  destination of issued MDU op
R1Num  in  AW  decode source 1 index
R2Num  in  AW  decode source 2 index
DecDestNum  in  AW  decode destination index (WAW check)
DecDestValid  in  1  decode instruction writes a register
Stall  out  1  decode must stall (RAW/WAW on pending MDU register)
PipeHold  out  1  pipeline must freeze and re-present its writeback next cycle
RegWrite  out  1  register file write enable
WbRegNum  out  AW  register file write index
WbData  out  DW  register file write data

Behaviour:
- Reset (rst=1 at rising edge): FIFO emptied, all busy bits 0, WaitCnt 0, PipeHold 0. While rst=1, RegWrite is forced 0. After reset: MdReady=1, Stall=0.
- Write-port outputs are combinational from this cycle's inputs and the FIFO head, so the register file captures them on the same cycle's falling edge.
- Grant priority, evaluated each cycle:
  1. PipeHold=1 and FIFO non-empty: FIFO head.
  2. PipeWe=1 and PipeHold=0: pipeline.
  3. FIFO non-empty: FIFO head.
  4. Otherwise: RegWrite=0.
- While PipeHold=1, PipeWe is ignored.
- FIFO:
  - Push on MdValid & MdReady.
  - Pop when the head is granted.
  - Push and pop in the same cycle are both honoured; at full, push plus pop is allowed only if MdReady was high.
  - MdReady = !full, registered-state based. Minimum MDU-to-regfile latency is 1 cycle.
- Scoreboard (busy[2**AW]):
  - Set busy[IssueRegNum] on IssueValid when IssueRegNum != 0.
  - Clear busy[WbRegNum] when a FIFO entry is granted.
  - Set and clear on the same register in the same cycle: set wins.
  - busy[0] is never set.
- Stall = busy[R1Num] | busy[R2Num] | (DecDestValid & busy[DecDestNum]). Combinational.
- Decode must not assert IssueValid while Stall=1 or while busy[IssueRegNum]=1. A violation is an assertion failure in simulation.
- Starvation:
  - WaitCnt increments each cycle the FIFO is non-empty and its head is not granted.
  - WaitCnt clears on any FIFO grant and whenever the FIFO is empty.
  - When WaitCnt reaches MAX_WAIT-1 and the head is not granted, PipeHold is registered high for exactly one cycle; the FIFO head is granted in that cycle.
  - PipeHold is never asserted on two consecutive cycles.
- Register 0: writes pass through unchanged (the register file does not guard r0), except as set by the optional feature.
- Reset mid-operation: buffered MDU results are discarded. The MDU is reset by the same rst.

Optional Feature:
- Macro REGSCHED_ZERO_GUARD_EN.
- Defined: any grant whose destination is 0 drives RegWrite=0; the grant and FIFO pop still occur. MDU results with MdRegNum=0 are accepted and dropped without entering the FIFO.
- Undefined: register-0 writes reach the register file like any other index.

Decomposition:
- Shared package regsched_pkg holds:
  - DW and AW defaults
  - grant-source enum GNT_NONE, GNT_PIPE, GNT_FIFO
  - wb_req_t struct {regnum, data}
- One sub-module, regsched_fifo: synchronous FIFO with push/pop/full/empty/head, parameterised by FIFO_DEPTH and the width of wb_req_t.
- Arbitration, scoreboard and starvation counter stay in the top module.

Test Plan:
1. Reset, then PipeWe=1, PipeRegNum=5, PipeData=0xDEADBEEF -> same cycle RegWrite=1, WbRegNum=5, WbData=0xDEADBEEF; r5 reads 0xDEADBEEF after the falling edge.
2. IssueValid with IssueRegNum=7; next cycle R1Num=7 -> Stall=1. MdValid (7, 0x12345678) with PipeWe=0 -> next cycle r7 written, busy[7] cleared, Stall drops.
3. Three back-to-back MdValid results with PipeWe held 1 -> MdReady=0 after two pushes. With MAX_WAIT=4, PipeHold=1 at cycle 4 after the first push; the FIFO head is written in that cycle; the pipeline write is deferred one cycle.
4. Same-cycle FIFO grant clearing r9 and IssueValid to r9 -> busy[9] remains 1.
5. rst asserted with two FIFO entries and busy[3]=1 -> next cycle MdReady=1, Stall=0, RegWrite=0; no stale writes ever appear.
6. With REGSCHED_ZERO_GUARD_EN: PipeWe to r0 -> RegWrite=0, r0 stays 0. Without it: r0 is written.

Source files
------------

// File: rtl/regsched_pkg.sv
// Shared types for the register-file write-port scheduler: default widths,
// grant-source encoding and the buffered writeback request.
package regsched_pkg;

    localparam int unsigned DEF_DW = 32;
    localparam int unsigned DEF_AW = 5;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_FIFO = 2'd2
    } gnt_e;

    typedef struct packed {
        logic [DEF_AW-1:0] regnum;
        logic [DEF_DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regsched_fifo.sv
// Small synchronous FIFO holding MDU results until they win the register-file
// write port. Head is visible combinationally; DEPTH must be a power of 2, >= 2.
module regsched_fifo
    import regsched_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = $bits(wb_req_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wptr_q, wptr_d;
    logic [PW:0]      rptr_q, rptr_d;
    logic             push_ok, pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign head  = mem_q[rptr_q[PW-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the register file's single write port between pipeline writeback and
// buffered MDU results. Optional macro REGSCHED_ZERO_GUARD_EN suppresses r0 writes.
module regfile_wb_sched
    import regsched_pkg::*;
#(
    parameter int unsigned DW         = regsched_pkg::DEF_DW,
    parameter int unsigned AW         = regsched_pkg::DEF_AW,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PipeWe,
    input  logic [AW-1:0] PipeRegNum,
    input  logic [DW-1:0] PipeData,
    input  logic          MdValid,
    output logic          MdReady,
    input  logic [AW-1:0] MdRegNum,
    input  logic [DW-1:0] MdData,
    input  logic          IssueValid,
    input  logic [AW-1:0] IssueRegNum,
    input  logic [AW-1:0] R1Num,
    input  logic [AW-1:0] R2Num,
    input  logic [AW-1:0] DecDestNum,
    input  logic          DecDestValid,
    output logic          Stall,
    output logic          PipeHold,
    output logic          RegWrite,
    output logic [AW-1:0] WbRegNum,
    output logic [DW-1:0] WbData
);

    localparam int unsigned NR  = 1 << AW;
    localparam int unsigned WCW = $clog2(MAX_WAIT) + 1;

    gnt_e           gnt;
    wb_req_t        md_req, fifo_head, wb_req;
    logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [NR-1:0]  busy_q, busy_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           hold_q, hold_d;

    always_comb begin
        md_req        = '0;
        md_req.regnum = MdRegNum;
        md_req.data   = MdData;
    end

    regsched_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(wb_req_t))
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push),
        .wdata(md_req),
        .pop  (fifo_pop),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    assign MdReady = !fifo_full;

`ifdef REGSCHED_ZERO_GUARD_EN
    // r0 results are accepted but never buffered.
    assign fifo_push = MdValid && !fifo_full && !rst && (MdRegNum != '0);
`else
    assign fifo_push = MdValid && !fifo_full && !rst;
`endif

    // A forced hold gives the FIFO head the port and ignores the pipeline request.
    always_comb begin
        gnt = GNT_NONE;
        if (hold_q && !fifo_empty) begin
            gnt = GNT_FIFO;
        end else if (PipeWe && !hold_q) begin
            gnt = GNT_PIPE;
        end else if (!fifo_empty) begin
            gnt = GNT_FIFO;
        end
    end

    always_comb begin
        wb_req = '0;
        if (gnt == GNT_FIFO) begin
            wb_req = fifo_head;
        end else begin
            wb_req.regnum = PipeRegNum;
            wb_req.data   = PipeData;
        end
    end

    assign fifo_pop = (gnt == GNT_FIFO) && !rst;
    assign WbRegNum = wb_req.regnum;
    assign WbData   = wb_req.data;

`ifdef REGSCHED_ZERO_GUARD_EN
    assign RegWrite = !rst && (gnt != GNT_NONE) && (wb_req.regnum != '0);
`else
    assign RegWrite = !rst && (gnt != GNT_NONE);
`endif

    // Issue after retire so a same-cycle set on the retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) busy_d[fifo_head.regnum] = 1'b0;
        if (IssueValid && (IssueRegNum != '0)) busy_d[IssueRegNum] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign Stall = busy_q[R1Num] | busy_q[R2Num] | (DecDestValid & busy_q[DecDestNum]);

    always_comb begin
        wait_d = (fifo_empty || fifo_pop) ? '0 : wait_q + WCW'(1);
        hold_d = !hold_q && !fifo_empty && !fifo_pop &&
                 ((wait_q + WCW'(1)) == WCW'(MAX_WAIT - 1));
    end

    assign PipeHold = hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            wait_q <= '0;
            hold_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            wait_q <= wait_d;
            hold_q <= hold_d;
        end
    end

    // Decode may re-issue a pending register only in the cycle its result retires.
    always_ff @(posedge clk) begin
        if (!rst && IssueValid) begin
            assert (!Stall && (!busy_q[IssueRegNum] ||
                    (fifo_pop && (fifo_head.regnum == IssueRegNum))));
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: scoreboard of expected register-file
// writes checked at each falling edge, plus direct checks of control outputs.
module tb_regfile_wb_sched;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          PipeWe;
    logic [AW-1:0] PipeRegNum;
    logic [DW-1:0] PipeData;
    logic          MdValid;
    logic          MdReady;
    logic [AW-1:0] MdRegNum;
    logic [DW-1:0] MdData;
    logic          IssueValid;
    logic [AW-1:0] IssueRegNum;
    logic [AW-1:0] R1Num;
    logic [AW-1:0] R2Num;
    logic [AW-1:0] DecDestNum;
    logic          DecDestValid;
    logic          Stall;
    logic          PipeHold;
    logic          RegWrite;
    logic [AW-1:0] WbRegNum;
    logic [DW-1:0] WbData;

    regfile_wb_sched #(
        .DW(DW),
        .AW(AW),
        .FIFO_DEPTH(2),
        .MAX_WAIT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PipeWe      (PipeWe),
        .PipeRegNum  (PipeRegNum),
        .PipeData    (PipeData),
        .MdValid     (MdValid),
        .MdReady     (MdReady),
        .MdRegNum    (MdRegNum),
        .MdData      (MdData),
        .IssueValid  (IssueValid),
        .IssueRegNum (IssueRegNum),
        .R1Num       (R1Num),
        .R2Num       (R2Num),
        .DecDestNum  (DecDestNum),
        .DecDestValid(DecDestValid),
        .Stall       (Stall),
        .PipeHold    (PipeHold),
        .RegWrite    (RegWrite),
        .WbRegNum    (WbRegNum),
        .WbData      (WbData)
    );

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] rf [32] = '{default: '0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: captures on the falling edge.
    always @(negedge clk) begin
        if (RegWrite) rf[WbRegNum] <= WbData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [AW-1:0] r, input logic [DW-1:0] d);
        exp_t e;
        e.r = r;
        e.d = d;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", RegWrite, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_regnum", WbRegNum, mon_e.r);
                chk("wb_data", WbData, mon_e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drv_pipe(input logic we, input logic [AW-1:0] r, input logic [DW-1:0] d);
        PipeWe     = we;
        PipeRegNum = r;
        PipeData   = d;
    endtask

    task automatic drv_md(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        MdValid  = v;
        MdRegNum = r;
        MdData   = d;
    endtask

    task automatic drv_issue(input logic v, input logic [AW-1:0] r);
        IssueValid  = v;
        IssueRegNum = r;
    endtask

    initial begin
        rst          = 1'b1;
        drv_pipe(1'b1, 5'd1, 32'h0000_0111);
        drv_md(1'b0, '0, '0);
        drv_issue(1'b0, '0);
        R1Num        = '0;
        R2Num        = '0;
        DecDestNum   = '0;
        DecDestValid = 1'b0;

        // Reset: write port forced off even with a pipeline request
        tick();
        settle();
        chk("rst_regwrite", RegWrite, 1'b0);
        tick();
        rst = 1'b0;
        drv_pipe(1'b0, '0, '0);
        settle();
        chk("post_rst_mdready", MdReady, 1'b1);
        chk("post_rst_stall", Stall, 1'b0);
        chk("post_rst_hold", PipeHold, 1'b0);
        chk("post_rst_regwrite", RegWrite, 1'b0);

        // 1: pipeline writeback passes straight through
        tick();
        drv_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
        exp_push(5'd5, 32'hDEAD_BEEF);
        settle();
        chk("t1_regwrite", RegWrite, 1'b1);
        chk("t1_wbreg", WbRegNum, 5'd5);
        chk("t1_wbdata", WbData, 32'hDEAD_BEEF);
        tick();
        drv_pipe(1'b0, '0, '0);
        chk("t1_rf5", rf[5], 32'hDEAD_BEEF);

        // 2: issue r7, RAW stall until its MDU result retires
        drv_issue(1'b1, 5'd7);
        settle();
        chk("t2_stall_pre", Stall, 1'b0);
        tick();
        drv_issue(1'b0, '0);
        R1Num = 5'd7;
        drv_md(1'b1, 5'd7, 32'h1234_5678);
        exp_push(5'd7, 32'h1234_5678);
        settle();
        chk("t2_stall", Stall, 1'b1);
        chk("t2_no_write", RegWrite, 1'b0);
        tick();
        drv_md(1'b0, '0, '0);
        settle();
        chk("t2_md_write", RegWrite, 1'b1);
        chk("t2_md_reg", WbRegNum, 5'd7);
        chk("t2_stall_hold", Stall, 1'b1);
        tick();
        settle();
        chk("t2_stall_clear", Stall, 1'b0);
        chk("t2_rf7", rf[7], 32'h1234_5678);
        R1Num = '0;

        // 3: MDU starved by continuous pipeline writes until a forced hold
        tick();
        drv_pipe(1'b1, 5'd10, 32'hA000_0000);
        drv_md(1'b1, 5'd11, 32'hB000_0000);
        exp_push(5'd10, 32'hA000_0000);
        settle();
        chk("t3a_mdready", MdReady, 1'b1);
        tick();
        drv_pipe(1'b1, 5'd12, 32'hA000_0001);
        drv_md(1'b1, 5'd13, 32'hB000_0001);
        exp_push(5'd12, 32'hA000_0001);
        settle();
        chk("t3b_mdready", MdReady, 1'b1);
        tick();
        drv_pipe(1'b1, 5'd15, 32'hA000_0002);
        drv_md(1'b1, 5'd14, 32'hB000_0002);
        exp_push(5'd15, 32'hA000_0002);
        settle();
        chk("t3c_mdready_full", MdReady, 1'b0);
        chk("t3c_hold", PipeHold, 1'b0);
        tick();
        drv_pipe(1'b1, 5'd16, 32'hA000_0003);
        exp_push(5'd16, 32'hA000_0003);
        settle();
        chk("t3d_hold", PipeHold, 1'b0);
        chk("t3d_mdready", MdReady, 1'b0);
        tick();
        drv_pipe(1'b1, 5'd17, 32'hA000_0004);
        exp_push(5'd11, 32'hB000_0000);
        settle();
        chk("t3e_hold", PipeHold, 1'b1);
        chk("t3e_wbreg", WbRegNum, 5'd11);
        chk("t3e_mdready", MdReady, 1'b0);
        tick();
        exp_push(5'd17, 32'hA000_0004);
        settle();
        chk("t3f_hold_once", PipeHold, 1'b0);
        chk("t3f_wbreg", WbRegNum, 5'd17);
        chk("t3f_mdready", MdReady, 1'b1);
        tick();
        drv_pipe(1'b0, '0, '0);
        drv_md(1'b0, '0, '0);
        exp_push(5'd13, 32'hB000_0001);
        settle();
        chk("t3g_wbreg", WbRegNum, 5'd13);
        tick();
        exp_push(5'd14, 32'hB000_0002);
        settle();
        chk("t3h_wbreg", WbRegNum, 5'd14);
        tick();
        settle();
        chk("t3_idle", RegWrite, 1'b0);

        // 4: set and clear of r9 in the same cycle, set wins
        tick();
        drv_issue(1'b1, 5'd9);
        settle();
        tick();
        drv_issue(1'b0, '0);
        drv_md(1'b1, 5'd9, 32'h0000_00A9);
        exp_push(5'd9, 32'h0000_00A9);
        settle();
        tick();
        drv_md(1'b0, '0, '0);
        drv_issue(1'b1, 5'd9);
        settle();
        chk("t4_regwrite", RegWrite, 1'b1);
        chk("t4_wbreg", WbRegNum, 5'd9);
        tick();
        drv_issue(1'b0, '0);
        R1Num = 5'd9;
        drv_md(1'b1, 5'd9, 32'h0000_00B9);
        exp_push(5'd9, 32'h0000_00B9);
        settle();
        chk("t4_busy_kept", Stall, 1'b1);
        tick();
        drv_md(1'b0, '0, '0);
        settle();
        chk("t4_second_wbreg", WbRegNum, 5'd9);
        tick();
        settle();
        chk("t4_stall_clear", Stall, 1'b0);
        R1Num = '0;

        // 5: reset with two buffered results and r3 pending
        tick();
        drv_issue(1'b1, 5'd3);
        settle();
        tick();
        drv_issue(1'b0, '0);
        drv_pipe(1'b1, 5'd20, 32'hC000_0000);
        drv_md(1'b1, 5'd3, 32'hD000_0003);
        exp_push(5'd20, 32'hC000_0000);
        settle();
        tick();
        drv_pipe(1'b1, 5'd21, 32'hC000_0001);
        drv_md(1'b1, 5'd4, 32'hD000_0004);
        exp_push(5'd21, 32'hC000_0001);
        settle();
        chk("t5_mdready_pre", MdReady, 1'b1);
        tick();
        drv_pipe(1'b0, '0, '0);
        drv_md(1'b0, '0, '0);
        R1Num = 5'd3;
        rst   = 1'b1;
        settle();
        chk("t5_full_pre_rst", MdReady, 1'b0);
        chk("t5_stall_pre_rst", Stall, 1'b1);
        chk("t5_rst_regwrite", RegWrite, 1'b0);
        tick();
        rst = 1'b0;
        settle();
        chk("t5_mdready", MdReady, 1'b1);
        chk("t5_stall", Stall, 1'b0);
        chk("t5_regwrite", RegWrite, 1'b0);
        tick();
        settle();
        chk("t5_no_stale", RegWrite, 1'b0);
        R1Num = '0;

        // 6: write to r0
        tick();
        drv_pipe(1'b1, 5'd0, 32'hFFFF_0000);
`ifdef REGSCHED_ZERO_GUARD_EN
        settle();
        chk("t6_r0_regwrite", RegWrite, 1'b0);
        tick();
        drv_pipe(1'b0, '0, '0);
        settle();
        chk("t6_rf0", rf[0], 32'h0000_0000);
`else
        exp_push(5'd0, 32'hFFFF_0000);
        settle();
        chk("t6_r0_regwrite", RegWrite, 1'b1);
        tick();
        drv_pipe(1'b0, '0, '0);
        settle();
        chk("t6_rf0", rf[0], 32'hFFFF_0000);
`endif

        tick();
        chk("sb_drained", sb_q.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
